// File: rtl/video_out_packer.sv
// video_out_packer: re-frames a read-latency-1 pixel stream into Avalon-ST video with sop/eop from width/height.
// Define VIDEO_OUT_TYPE_HDR_EN to prefix each frame with a type-0 header beat.
module video_out_packer #(
    parameter int BITWIDTH   = 32,
    parameter int SKID_DEPTH = 4,
    parameter int SKID_AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         width,
    input  logic [15:0]         height,
    output logic [BITWIDTH-1:0] dout_data,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_sop,
    output logic                dout_eop,
    output logic                busy,
    output logic                frame_done,
    output logic                skid_overflow
);
`ifdef VIDEO_OUT_TYPE_HDR_EN
    typedef enum logic [1:0] {IDLE, HDR, ACTIVE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
`endif
    localparam logic [SKID_AW:0]   DEPTH = (SKID_AW+1)'(SKID_DEPTH);
    localparam logic [SKID_AW-1:0] LAST  = SKID_AW'(SKID_DEPTH - 1);

    state_t              state;
    logic [BITWIDTH-1:0] mem [SKID_DEPTH];
    logic [SKID_AW-1:0]  rd_ptr, wr_ptr;
    logic [SKID_AW:0]    occ;
    logic [15:0]         x, y, wm1, hm1;
    logic                rdy_d, active, hdr, full, rd, wr, first, last;

    always_comb begin
        active     = state == ACTIVE;
`ifdef VIDEO_OUT_TYPE_HDR_EN
        hdr        = state == HDR;
`else
        hdr        = 1'b0;
`endif
        full       = occ == DEPTH;
        first      = x == 16'd0 && y == 16'd0;
        last       = x == wm1 && y == hm1;
        dout_valid = hdr | (active & occ != '0);
        dout_data  = hdr ? '0 : mem[rd_ptr];
        rd         = active & occ != '0 & dout_ready;
        wr         = in_valid & (~full | rd);
        // counting the registered request reserves room for the beat still in flight
        in_ready   = active & ((occ + {{SKID_AW{1'b0}}, rdy_d}) < DEPTH);
`ifdef VIDEO_OUT_TYPE_HDR_EN
        dout_sop   = hdr;
`else
        dout_sop   = active & occ != '0 & first;
`endif
        dout_eop   = active & occ != '0 & last;
    end

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            occ           <= '0;
            x             <= '0;
            y             <= '0;
            wm1           <= '0;
            hm1           <= '0;
            rdy_d         <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            skid_overflow <= 1'b0;
        end else begin
            rdy_d      <= in_ready;
            frame_done <= 1'b0;
            if (wr) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            occ <= occ + {{SKID_AW{1'b0}}, wr} - {{SKID_AW{1'b0}}, rd};
            if (in_valid & full & ~rd) skid_overflow <= 1'b1;
            case (state)
                IDLE: begin
                    wm1 <= width - 16'd1;
                    hm1 <= height - 16'd1;
                    x   <= '0;
                    y   <= '0;
                    if (width != 16'd0 && height != 16'd0) begin
`ifdef VIDEO_OUT_TYPE_HDR_EN
                        state <= HDR;
`else
                        state <= ACTIVE;
`endif
                        busy  <= 1'b1;
                    end
                end
`ifdef VIDEO_OUT_TYPE_HDR_EN
                HDR: if (dout_ready) state <= ACTIVE;
`endif
                ACTIVE: if (rd) begin
                    if (x == wm1) begin
                        x <= '0;
                        if (y == hm1) begin
                            y          <= '0;
                            state      <= DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else y <= y + 16'd1;
                    end else x <= x + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_video_out_packer.sv
// tb_video_out_packer: directed frames against a modelled read-latency-1 upstream FIFO.
module tb_video_out_packer;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, dout_ready = 1'b1;
    logic [15:0] width = '0, height = '0;
    logic        in_ready, dout_valid, dout_sop, dout_eop, busy, frame_done, skid_overflow;
    logic [31:0] dout_data;

    video_out_packer dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .width(width), .height(height), .dout_data(dout_data), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_sop(dout_sop), .dout_eop(dout_eop), .busy(busy),
        .frame_done(frame_done), .skid_overflow(skid_overflow)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0, done_cnt = 0, cyc = 0;
    bit          tog = 0, saw_stall = 0;
    logic [31:0] src_q[$], got_d[$];
    logic        got_s[$], got_e[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("reset_outs", 32'({in_ready, dout_valid, dout_sop, dout_eop, busy, frame_done, skid_overflow}), 32'd0);
        @(negedge clk) rst = 1'b1;
    endtask

    // One clock: observe at negedge, then act as the upstream FIFO (data one cycle after request).
    task automatic tick();
        bit req;
        @(negedge clk);
        if (dout_valid && dout_ready) begin
            got_d.push_back(dout_data);
            got_s.push_back(dout_sop);
            got_e.push_back(dout_eop);
            if (dout_eop) begin
                width = '0;
                height = '0;
            end
        end
        if (frame_done) done_cnt++;
        if (busy && !in_ready) saw_stall = 1;
        req = in_ready && src_q.size() != 0;
        @(posedge clk);
        #1;
        in_valid = req;
        if (req) in_data = src_q.pop_front();
        cyc++;
        dout_ready = tog ? (cyc % 2 == 0) : 1'b1;
    endtask

    task automatic run_frame(input string nm, input int n, input logic [15:0] w, input logic [15:0] h,
                             input logic [31:0] base, input bit t, input bit rs, input int stop_at);
        logic [31:0] sm, em;
        if (rs) do_reset();
        src_q.delete();
        got_d.delete();
        got_s.delete();
        got_e.delete();
        done_cnt = 0;
        saw_stall = 0;
        tog = t;
        for (int i = 0; i < n; i++) src_q.push_back(base + 32'(i));
        width = w;
        height = h;
        for (int k = 0; k < 300 && got_d.size() < stop_at; k++) tick();
        if (stop_at < n) begin
            chk({nm, "_partial"}, got_d.size(), stop_at);
            return;
        end
        repeat (6) tick();
        chk({nm, "_count"}, got_d.size(), n);
        sm = '0;
        em = '0;
        for (int i = 0; i < got_d.size(); i++) begin
            chk({nm, "_data"}, got_d[i], base + 32'(i));
            sm[i] = got_s[i];
            em[i] = got_e[i];
        end
        chk({nm, "_sop_pos"}, sm, 32'd1);
        chk({nm, "_eop_pos"}, em, 32'd1 << (n - 1));
        chk({nm, "_frame_done"}, done_cnt, 1);
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_no_overflow"}, skid_overflow, 0);
        if (t) chk({nm, "_in_ready_throttled"}, saw_stall, 1);
    endtask

    initial begin
        bit bad;
        run_frame("basic", 8, 16'd4, 16'd2, 32'h0, 0, 1, 8);
        run_frame("toggle", 8, 16'd4, 16'd2, 32'h0, 1, 1, 8);
        run_frame("single", 1, 16'd1, 16'd1, 32'hA5, 0, 1, 1);

        do_reset();
        width = '0;
        height = 16'd4;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready || busy) bad = 1;
        end
        chk("w0_idle", bad, 0);
        run_frame("w2h1", 2, 16'd2, 16'd1, 32'h100, 0, 0, 2);

        do_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) chk("ovf_full_no_err", skid_overflow, 0);
            in_valid = 1'b1;
            in_data = 32'(i);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("ovf_set", skid_overflow, 1);
        repeat (5) @(posedge clk);
        #1 chk("ovf_sticky", skid_overflow, 1);
        do_reset();
        @(negedge clk) chk("ovf_cleared", skid_overflow, 0);

        run_frame("mid", 8, 16'd4, 16'd2, 32'h10, 0, 1, 3);
        run_frame("after_rst", 8, 16'd4, 16'd2, 32'h20, 0, 1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/video_out_packer.md
Name: video_out_packer

Overview:
- Downstream neighbour of the video input FIFO stage. Consumes its read-latency-1 pixel stream (valid arrives one cycle after ready+non-empty).
- Re-frames pixels into a ready-latency-0 Avalon-ST stream, regenerating sop/eop from programmed width/height counters.
- Contains a small skid buffer that absorbs the one-cycle in-flight read, plus frame status outputs.

Parameters:
- BITWIDTH, 32, pixel word width.
- SKID_DEPTH, 4, skid buffer entries (min 2).
- SKID_AW, 2, log2(SKID_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_data  in  BITWIDTH  pixel from upstream FIFO.
- in_valid  in  1  in_data valid; arrives one cycle after an accepted read.
- in_ready  out  1  read request to upstream (drives its source_ready).
- width  in  16  pixels per line; sampled at frame start.
- height  in  16  lines per frame; sampled at frame start.
- dout_data  out  BITWIDTH  output pixel.
- dout_valid  out  1  output beat valid.
- dout_ready  in  1  downstream accept, ready latency 0.
- dout_sop  out  1  first beat of frame packet.
- dout_eop  out  1  last beat of frame packet.
- busy  out  1  high from frame start until the eop beat is accepted.
- frame_done  out  1  one-cycle pulse on the cycle after the eop beat is accepted.
- skid_overflow  out  1  sticky error: in_valid arrived while skid was full.

Behaviour:
- Reset (rst=0, async) values: in_ready=0, dout_valid=0, dout_sop=0, dout_eop=0, busy=0, frame_done=0, skid_overflow=0. Skid occupancy, x, y, rdy_d and state are cleared. A reset mid-frame discards partial frame state; the next frame starts clean.
- Skid buffer: SKID_DEPTH-entry circular FIFO.
  - Writes on in_valid.
  - Reads on dout_valid & dout_ready.
  - A simultaneous read and write leaves occupancy unchanged.
  - Pointers wrap modulo SKID_DEPTH.
- Credit rule: rdy_d is in_ready registered. in_ready = (state==ACTIVE) & (occ + rdy_d < SKID_DEPTH), so one in-flight beat always fits.
- If in_valid arrives while occ==SKID_DEPTH and no read occurs that cycle: the beat is dropped and skid_overflow sets. skid_overflow clears only on reset.
- dout_valid = (occ != 0) & (state==ACTIVE). dout_data is the skid head, combinational from the skid RAM/regs.
- State machine:
  - IDLE: latch width -> W and height -> H. If W!=0 and H!=0, go to ACTIVE next cycle and set busy. If either is 0, remain in IDLE with in_ready=0.
  - ACTIVE: counters x (0..W-1) and y (0..H-1) advance only on an accepted output beat.
    - x wraps to 0 and y increments when x==W-1.
    - On accepting the beat with x==W-1 and y==H-1: go to DONE, clear x and y.
  - DONE: one cycle. frame_done=1, busy=0, then return to IDLE.
- dout_sop = dout_valid & x==0 & y==0.
- dout_eop = dout_valid & x==W-1 & y==H-1.
- W=1, H=1: a single beat carries both sop and eop.
- Beats left in the skid at eop (upstream over-delivery) stay in the skid and become the next frame's first pixels. width/height changes mid-frame have no effect until the next IDLE.
- Counter arithmetic is 16-bit unsigned. W-1 and H-1 are precomputed at latch time.
- Latency: a pixel entering an empty skid is presented on dout the cycle after in_valid.
- Throughput: with dout_ready held high, one pixel per cycle sustained.

Optional Feature:
- Macro VIDEO_OUT_TYPE_HDR_EN.
- Defined: ACTIVE is preceded by HDR state, in which the block emits one header beat:
  - dout_data = {BITWIDTH-4 zeros, 4'h0}, i.e. Avalon-ST video packet type 0.
  - dout_valid=1, dout_sop=1. No skid read.
  - Advances to ACTIVE on dout_ready.
  - In ACTIVE, no pixel carries sop; eop is unchanged.
- Not defined: no HDR state; sop is on the first pixel as described above.

Test Plan:
- W=4, H=2, upstream delivers 8 pixels 0..7, dout_ready=1 -> 8 beats 0..7 in order; sop on beat 0, eop on beat 7; frame_done pulses once; busy low afterwards.
- Same frame with dout_ready toggling 1,0,1,0 -> in_ready falls when occ+rdy_d reaches 4; no skid_overflow; output order and sop/eop positions unchanged.
- W=1, H=1, single pixel 0xA5 -> one beat with sop=1 and eop=1, then frame_done.
- W=0 -> in_ready stays 0 and busy stays 0 for 20 cycles; then set W=2, H=1 -> frame of 2 beats completes.
- Force in_valid for 5 consecutive cycles with dout_ready=0 -> skid_overflow=1 and stays high until rst=0; after reset all outputs are 0.
- Reset asserted after 3 of 8 beats (W=4, H=2), then a full new frame -> sop on the new frame's first pixel; eop after 8 beats.
